// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and data access, one transaction at a time.
// Latency: 4 cycles minimum per access (grant, address, wait, response); each bus wait cycle adds one.
// Backpressure: bus_req and all bus fields hold until bus_addr_ok; requesters see stall_* until their valid pulse.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_valid,
    input  logic                  flush,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_valid,
    output logic                  stall_if,
    output logic                  stall_mem,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_W-1:0]     bus_rdata
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                owner_d;     // 1 = current transaction belongs to the data side
    logic                last_d;      // 1 = most recent grant went to the data side
    logic                drop;        // fetch result must be discarded after a flush
    logic                grant_d;
    logic                flush_hit;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    // Data normally wins; fetch wins a tie when data took the previous grant, so loads cannot starve fetch.
    always_comb begin
        grant_d = d_req;
        if (d_req && i_req && last_d) begin
            grant_d = 1'b0;
        end
    end

    // A flush only matters while a fetch is still in flight on the bus.
    assign flush_hit = flush && !owner_d && (state == S_ADDR || state == S_WAIT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; the address request is never withdrawn once issued.
    always_comb begin
        state_nxt = state;
        bus_req   = 1'b0;
        i_valid   = 1'b0;
        d_valid   = 1'b0;
        case (state)
            S_IDLE: if (i_req || d_req) state_nxt = S_ADDR;
            S_ADDR: begin
                bus_req = 1'b1;
                if (bus_addr_ok) state_nxt = S_WAIT;
            end
            S_WAIT: if (bus_data_ok) state_nxt = S_RESP;
            S_RESP: begin
                i_valid   = !owner_d && !drop;
                d_valid   = owner_d;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latch the granted request, owner and grant history; track the flush drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d <= 1'b0;
            last_d  <= 1'b0;
            drop    <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else begin
            if (state == S_IDLE && (i_req || d_req)) begin
                owner_d <= grant_d;
                last_d  <= grant_d;
                if (grant_d) begin
                    addr_q  <= d_addr;
                    wr_q    <= d_we;
                    wstrb_q <= d_we ? d_wstrb : '0;
                    wdata_q <= d_wdata;
                end else begin
                    addr_q  <= i_addr;
                    wr_q    <= 1'b0;
                    wstrb_q <= '0;
                    wdata_q <= '0;
                end
            end
            if (flush_hit) begin
                drop <= 1'b1;
            end else if (state == S_RESP) begin
                drop <= 1'b0;
            end
        end
    end

    // Capture response data for the owner; a flushed fetch leaves i_rdata untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else if (state == S_WAIT && bus_data_ok) begin
            if (owner_d) begin
                d_rdata_q <= bus_rdata;
            end else if (!(drop || flush_hit)) begin
                i_rdata_q <= bus_rdata;
            end
        end
    end

    assign bus_addr  = addr_q;
    assign bus_wr    = wr_q;
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = i_req & ~i_valid;
    assign stall_mem = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: cycle table, directed corner sequences, randomized run.
// Latency: n/a (bench).
// Backpressure: bench plays both requesters and the bus slave, with random address/data waits.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        flush = 1'b0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_wstrb = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;

    int n_vec = 0;
    int n_bad = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .flush(flush),
        .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of hand-driven stimulus (loads only), outputs settle 1 time unit later.
    task automatic put(input logic ir, input logic [31:0] ia, input logic fl, input logic dr,
                       input logic [31:0] da, input logic aok, input logic dok, input logic [31:0] rd);
        @(negedge clk);
        i_req = ir; i_addr = ia; flush = fl;
        d_req = dr; d_addr = da; d_we = 1'b0; d_wstrb = 4'hF; d_wdata = '0;
        bus_addr_ok = aok; bus_data_ok = dok; bus_rdata = rd;
        #1;
    endtask

    // Per-cycle table record; flag bits: ir dr we aok dok | exp: bus_req bus_wr i_valid d_valid stall_if stall_mem
    typedef struct {
        logic        ir, dr, we, aok, dok;
        logic [31:0] da, rd;
        logic        ebr, ewr, eiv, edv, esi, esm;
        logic [31:0] eaddr, erd;
    } vec_t;

    function automatic vec_t mk(input logic [10:0] f, input logic [31:0] da, input logic [31:0] rd,
                                input logic [31:0] eaddr, input logic [31:0] erd);
        vec_t v;
        {v.ir, v.dr, v.we, v.aok, v.dok, v.ebr, v.ewr, v.eiv, v.edv, v.esi, v.esm} = f;
        v.da = da; v.rd = rd; v.eaddr = eaddr; v.erd = erd;
        return v;
    endfunction

    vec_t tbl[21];

    // Reference-model state for the randomized run (transaction timeline, not cycle states).
    bit          have, m_own_d, m_last_d, m_drop, m_wr, exp_breq, exp_iv, exp_dv, fl, aok, dok, done;
    int          t_grant, t_aok, t_dok, idle_from;
    logic [31:0] m_addr, m_wdata, m_irdata, m_drdata, rd;
    logic [3:0]  m_wstrb;

    initial begin
        // Simultaneous requests then alternating grants: D, I, D.
        tbl[0]  = mk(11'b11000000011, 32'h100, 32'h0,        32'h0,   32'h0);
        tbl[1]  = mk(11'b11010100011, 32'h100, 32'h0,        32'h100, 32'h0);
        tbl[2]  = mk(11'b11001000011, 32'h100, 32'hDEADBEEF, 32'h0,   32'h0);
        tbl[3]  = mk(11'b11000000110, 32'h100, 32'h0,        32'h0,   32'hDEADBEEF);
        tbl[4]  = mk(11'b11000000011, 32'h104, 32'h0,        32'h0,   32'h0);
        tbl[5]  = mk(11'b11010100011, 32'h104, 32'h0,        32'h80,  32'h0);
        tbl[6]  = mk(11'b11001000011, 32'h104, 32'hCAFEF00D, 32'h0,   32'h0);
        tbl[7]  = mk(11'b11000001001, 32'h104, 32'h0,        32'h0,   32'hCAFEF00D);
        tbl[8]  = mk(11'b01000000001, 32'h104, 32'h0,        32'h0,   32'h0);
        tbl[9]  = mk(11'b01010100001, 32'h104, 32'h0,        32'h104, 32'h0);
        tbl[10] = mk(11'b01001000001, 32'h104, 32'h11112222, 32'h0,   32'h0);
        tbl[11] = mk(11'b01000000100, 32'h104, 32'h0,        32'h0,   32'h11112222);
        tbl[12] = mk(11'b00000000000, 32'h0,   32'h0,        32'h0,   32'h0);
        // Store with addr_ok three cycles late: seven-cycle access, single d_valid.
        tbl[13] = mk(11'b01100000001, 32'h40,  32'h0,        32'h0,   32'h0);
        tbl[14] = mk(11'b01100110001, 32'h40,  32'h0,        32'h40,  32'h0);
        tbl[15] = mk(11'b01100110001, 32'h40,  32'h0,        32'h40,  32'h0);
        tbl[16] = mk(11'b01100110001, 32'h40,  32'h0,        32'h40,  32'h0);
        tbl[17] = mk(11'b01110110001, 32'h40,  32'h0,        32'h40,  32'h0);
        tbl[18] = mk(11'b01101000001, 32'h40,  32'h0,        32'h0,   32'h0);
        tbl[19] = mk(11'b01100000100, 32'h40,  32'h0,        32'h0,   32'h0);
        tbl[20] = mk(11'b00000000000, 32'h0,   32'h0,        32'h0,   32'h0);

        // Reset state.
        #2;
        chk("reset bus_req",   32'(bus_req),   32'h0);
        chk("reset bus_wr",    32'(bus_wr),    32'h0);
        chk("reset bus_wstrb", 32'(bus_wstrb), 32'h0);
        chk("reset bus_addr",  bus_addr,       32'h0);
        chk("reset bus_wdata", bus_wdata,      32'h0);
        chk("reset i_valid",   32'(i_valid),   32'h0);
        chk("reset d_valid",   32'(d_valid),   32'h0);
        chk("reset i_rdata",   i_rdata,        32'h0);
        chk("reset d_rdata",   d_rdata,        32'h0);
        chk("reset stall_if",  32'(stall_if),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            i_req = tbl[k].ir; i_addr = 32'h80; flush = 1'b0;
            d_req = tbl[k].dr; d_we = tbl[k].we; d_addr = tbl[k].da;
            d_wstrb = 4'h3; d_wdata = 32'h1234;
            bus_addr_ok = tbl[k].aok; bus_data_ok = tbl[k].dok; bus_rdata = tbl[k].rd;
            #1;
            chk($sformatf("tbl[%0d] bus_req", k), 32'(bus_req), 32'(tbl[k].ebr));
            if (tbl[k].ebr) begin
                chk($sformatf("tbl[%0d] bus_addr", k), bus_addr, tbl[k].eaddr);
                chk($sformatf("tbl[%0d] bus_wr", k), 32'(bus_wr), 32'(tbl[k].ewr));
                chk($sformatf("tbl[%0d] bus_wstrb", k), 32'(bus_wstrb), tbl[k].ewr ? 32'h3 : 32'h0);
                if (tbl[k].ewr) chk($sformatf("tbl[%0d] bus_wdata", k), bus_wdata, 32'h1234);
            end
            chk($sformatf("tbl[%0d] i_valid", k), 32'(i_valid), 32'(tbl[k].eiv));
            chk($sformatf("tbl[%0d] d_valid", k), 32'(d_valid), 32'(tbl[k].edv));
            if (tbl[k].eiv) chk($sformatf("tbl[%0d] i_rdata", k), i_rdata, tbl[k].erd);
            if (tbl[k].edv) chk($sformatf("tbl[%0d] d_rdata", k), d_rdata, tbl[k].erd);
            chk($sformatf("tbl[%0d] stall_if", k), 32'(stall_if), 32'(tbl[k].esi));
            chk($sformatf("tbl[%0d] stall_mem", k), 32'(stall_mem), 32'(tbl[k].esm));
        end

        // Flush while the fetch waits for data: result dropped, redirected fetch serviced normally.
        put(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        put(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("flush addr", bus_addr, 32'h300);
        put(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        put(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0BAD0);
        put(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("flush i_valid dropped", 32'(i_valid), 32'h0);
        chk("flush i_rdata kept", i_rdata, 32'hCAFEF00D);
        chk("flush stall_if", 32'(stall_if), 32'h1);
        put(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("flush idle i_valid", 32'(i_valid), 32'h0);
        put(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("refetch bus_req", 32'(bus_req), 32'h1);
        chk("refetch addr", bus_addr, 32'h200);
        put(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0A0A0A0A);
        put(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("refetch i_valid", 32'(i_valid), 32'h1);
        chk("refetch i_rdata", i_rdata, 32'h0A0A0A0A);

        // Address back-pressure for 10 cycles with a data request waiting behind the fetch.
        put(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            put(1'b1, 32'h500, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0);
            chk($sformatf("bp[%0d] bus_req", k), 32'(bus_req), 32'h1);
            chk($sformatf("bp[%0d] bus_addr", k), bus_addr, 32'h500);
            chk($sformatf("bp[%0d] bus_wr", k), 32'(bus_wr), 32'h0);
            chk($sformatf("bp[%0d] bus_wstrb", k), 32'(bus_wstrb), 32'h0);
            chk($sformatf("bp[%0d] stall_if", k), 32'(stall_if), 32'h1);
            chk($sformatf("bp[%0d] stall_mem", k), 32'(stall_mem), 32'h1);
        end
        put(1'b1, 32'h500, 1'b0, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0);
        put(1'b1, 32'h500, 1'b0, 1'b1, 32'h600, 1'b0, 1'b1, 32'h55AA55AA);
        put(1'b1, 32'h500, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0);
        chk("bp i_valid", 32'(i_valid), 32'h1);
        chk("bp i_rdata", i_rdata, 32'h55AA55AA);
        chk("bp stall_mem", 32'(stall_mem), 32'h1);

        // Reset in the middle of a data access; a late data_ok after release is ignored.
        put(1'b0, 32'h0, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0);
        put(1'b0, 32'h0, 1'b0, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0);
        chk("rst pre addr", bus_addr, 32'h600);
        put(1'b0, 32'h0, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rst bus_req", 32'(bus_req), 32'h0);
        chk("rst d_valid", 32'(d_valid), 32'h0);
        chk("rst i_valid", 32'(i_valid), 32'h0);
        chk("rst bus_addr", bus_addr, 32'h0);
        chk("rst i_rdata", i_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; d_req = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            put(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk($sformatf("late[%0d] d_valid", k), 32'(d_valid), 32'h0);
            chk($sformatf("late[%0d] d_rdata", k), d_rdata, 32'h0);
        end

        // Randomized run against a transaction-timeline model.
        @(negedge clk);
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; flush = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        have = 0; m_last_d = 0; m_drop = 0; m_own_d = 0; m_wr = 0;
        m_irdata = '0; m_drdata = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        t_grant = -1; t_aok = -1; t_dok = -1; idle_from = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            done     = have && t_dok >= 0 && cyc == t_dok + 1;
            exp_breq = have && cyc > t_grant && t_aok < 0;
            exp_iv   = done && !m_own_d && !m_drop;
            exp_dv   = done && m_own_d;
            chk("rnd bus_req", 32'(bus_req), 32'(exp_breq));
            if (exp_breq) begin
                chk("rnd bus_addr", bus_addr, m_addr);
                chk("rnd bus_wr", 32'(bus_wr), 32'(m_wr));
                chk("rnd bus_wstrb", 32'(bus_wstrb), 32'(m_wstrb));
                if (m_wr) chk("rnd bus_wdata", bus_wdata, m_wdata);
            end
            chk("rnd i_valid", 32'(i_valid), 32'(exp_iv));
            chk("rnd d_valid", 32'(d_valid), 32'(exp_dv));
            chk("rnd i_rdata", i_rdata, m_irdata);
            chk("rnd d_rdata", d_rdata, m_drdata);
            if (done) begin
                have = 0;
                idle_from = cyc + 1;
                if (exp_iv) i_req = 1'b0;
                if (exp_dv) d_req = 1'b0;
            end
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_addr = $urandom & 32'hFFFFFFFC;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_wstrb = 4'($urandom);
                d_addr = $urandom & 32'hFFFFFFFC; d_wdata = $urandom;
            end
            fl = ($urandom_range(0, 7) == 0);
            if (fl && have && !m_own_d && cyc > t_grant && t_dok < 0) begin
                m_drop = 1; i_addr = $urandom & 32'hFFFFFFFC;
            end
            if (!have && cyc >= idle_from && (i_req || d_req)) begin
                m_own_d = d_req && !(i_req && m_last_d);
                m_last_d = m_own_d;
                have = 1; t_grant = cyc; t_aok = -1; t_dok = -1; m_drop = 0;
                if (m_own_d) begin
                    m_addr = d_addr; m_wr = d_we; m_wstrb = d_we ? d_wstrb : 4'h0; m_wdata = d_wdata;
                end else begin
                    m_addr = i_addr; m_wr = 0; m_wstrb = 4'h0; m_wdata = '0;
                end
            end
            aok = 0; dok = 0; rd = $urandom;
            if (exp_breq) begin
                aok = ($urandom_range(0, 2) == 0);
                if (aok) t_aok = cyc;
                else dok = ($urandom_range(0, 7) == 0);
            end else if (have && t_aok >= 0 && t_dok < 0 && cyc > t_aok) begin
                dok = ($urandom_range(0, 1) == 0);
                if (dok) begin
                    t_dok = cyc;
                    if (m_own_d) m_drdata = rd;
                    else if (!m_drop) m_irdata = rd;
                end
            end else begin
                dok = ($urandom_range(0, 7) == 0);
            end
            bus_addr_ok = aok; bus_data_ok = dok; bus_rdata = rd; flush = fl;
            #1;
            chk("rnd stall_if", 32'(stall_if), 32'(i_req && !exp_iv));
            chk("rnd stall_mem", 32'(stall_mem), 32'(d_req && !exp_dv));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
